// File: rtl/pi_leibniz_sequencer.sv
// Leibniz-series pi sequencer: drives a non_restoring_divider once per term and accumulates 4/(2k+1) with alternating sign.
// Optional WAIT timeout (err flag, partial result) when PI_SEQ_TIMEOUT_EN is defined.
module pi_leibniz_sequencer #(
  parameter int P_WIDTH   = 32,
  parameter int P_FRAC    = 28,
  parameter int P_CNT_W   = 16,
  parameter int P_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [P_CNT_W-1:0] n_terms,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [P_WIDTH:0]   pi_out,
  output logic               div_start,
  output logic [P_WIDTH-1:0] div_dividend,
  output logic [P_WIDTH-1:0] div_divisor,
  input  logic [P_WIDTH-1:0] div_quotient,
  input  logic               div_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_FINISH
  } state_t;

  localparam logic [P_WIDTH-1:0] DIVIDEND = {{(P_WIDTH-3){1'b0}}, 3'b100} << P_FRAC;

  state_t               state;
  logic [P_CNT_W-1:0]   k;
  logic [P_CNT_W-1:0]   k_last;
  logic [P_CNT_W-1:0]   k_inc;
  logic [P_WIDTH-1:0]   q;
  logic [P_WIDTH:0]     acc;
  logic [P_WIDTH:0]     q_ext;

  assign k_inc = k + 1'b1;
  assign q_ext = {1'b0, q};

  // Divisor 2k+1 built by concatenation, so it is always odd and never zero.
  function automatic logic [P_WIDTH-1:0] odd_of(input logic [P_CNT_W-1:0] idx);
    return {{(P_WIDTH-P_CNT_W-1){1'b0}}, idx, 1'b1};
  endfunction

`ifdef PI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(P_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  // Timeout disabled: err is constant and P_TIMEOUT has no function.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (P_TIMEOUT > 0);
  assign err = 1'b0;
`endif

  // NOTE: state and every output are registers in one clocked block, so all use <=;
  // outputs change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_start    <= 1'b0;
      pi_out       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      acc          <= '0;
      k            <= '0;
      k_last       <= '0;
      q            <= '0;
`ifdef PI_SEQ_TIMEOUT_EN
      err          <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            k      <= '0;
            k_last <= n_terms - 1'b1;
            busy   <= 1'b1;
`ifdef PI_SEQ_TIMEOUT_EN
            err    <= 1'b0;
`endif
            if (n_terms != '0) begin
              state        <= S_ISSUE;
              div_start    <= 1'b1;
              div_dividend <= DIVIDEND;
              div_divisor  <= odd_of('0);
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef PI_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (div_done) begin
            q     <= div_quotient;
            state <= S_ACCUM;
          end
`ifdef PI_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_ACCUM: begin
          acc <= k[0] ? acc - q_ext : acc + q_ext;
          if (k == k_last) begin
            state <= S_FINISH;
          end else begin
            k           <= k_inc;
            state       <= S_ISSUE;
            div_start   <= 1'b1;
            div_divisor <= odd_of(k_inc);
          end
        end
        S_FINISH: begin
          pi_out <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
